// File: rtl/mult_seq_pkg.sv
// ---------------------------------------------------------------------------
// mult_seq_pkg
//  Shared definitions for the sequential shift-add multiplier:
//   - control FSM state encoding
//   - width helper for the iteration counter
//  No ports; imported by mult_seq and mult_seq_ctrl.
// ---------------------------------------------------------------------------
package mult_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Counter width able to hold the values 0..width inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
//  Control FSM and iteration counter of the sequential multiplier.
//  Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start_i        in   operation request, accepted in IDLE and DONE
//   mplier_zero_i  in   multiplier bits above bit 0 are all zero
//   load_o         out  capture operands this cycle
//   step_o         out  perform one shift-add iteration this cycle
//   finish_o       out  this iteration is the last one; latch the result
//   busy_o         out  FSM is in RUN
//   done_o         out  FSM is in DONE (one-cycle pulse)
//   iters_o        out  iterations used, valid while finish_o is high
// ---------------------------------------------------------------------------
module mult_seq_ctrl
   import mult_seq_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit EARLY_EXIT = 1'b1,
   parameter int CW         = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          mplier_zero_i,
   output logic          load_o,
   output logic          step_o,
   output logic          finish_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [CW-1:0] iters_o
);

   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_s;

   // State and remaining-iteration counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_o   = 1'b0;
      step_o   = 1'b0;
      finish_o = 1'b0;
      // cnt_q still holds the pre-decrement value during the current step.
      iters_o  = CNT_INIT - cnt_q + CW'(1);
      last_s   = (cnt_q == CW'(1)) || ((EARLY_EXIT == 1'b1) && mplier_zero_i);

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               load_o  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            step_o = 1'b1;
            cnt_d  = cnt_q - CW'(1);
            if (last_s) begin
               finish_o = 1'b1;
               state_d  = ST_DONE;
            end else begin
               state_d  = ST_RUN;
            end
         end
         ST_DONE: begin
            // A held start chains straight into the next operation.
            if (start_i) begin
               load_o  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy_o = (state_q == ST_RUN);
   assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/mult_seq.sv
// ---------------------------------------------------------------------------
// mult_seq
//  Parametrised sequential shift-add multiplier with start/done handshake.
//  Full 2*WIDTH-bit product, runtime signed/unsigned mode, optional early
//  exit once the remaining multiplier bits are zero.
//  Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled while not busy
//   signed_mode  in   1: operands are two's complement (sampled with start)
//   a_in         in   multiplicand (sampled with start)
//   b_in         in   multiplier (sampled with start)
//   busy         out  operation in progress
//   done         out  one-cycle pulse, prod valid
//   prod         out  product, held until the next completion
//   iter_cnt     out  iterations used by the last operation
// ---------------------------------------------------------------------------
module mult_seq
   import mult_seq_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit EARLY_EXIT = 1'b1,
   parameter int CW         = cnt_width(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod,
   output logic [CW-1:0]      iter_cnt
);

   localparam int W2 = 2 * WIDTH;

   logic [W2-1:0]    mcand_q, mcand_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [W2-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic             neg_q, neg_d;
   logic [CW-1:0]    iter_q, iter_d;

   logic [WIDTH-1:0] a_mag_s, b_mag_s;
   logic [W2-1:0]    acc_next_s;
   logic             mplier_zero_s;
   logic             load_s, step_s, finish_s, busy_s, done_s;
   logic [CW-1:0]    iters_s;

   mult_seq_ctrl #(
      .WIDTH      (WIDTH),
      .EARLY_EXIT (EARLY_EXIT),
      .CW         (CW)
   ) u_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .mplier_zero_i (mplier_zero_s),
      .load_o        (load_s),
      .step_o        (step_s),
      .finish_o      (finish_s),
      .busy_o        (busy_s),
      .done_o        (done_s),
      .iters_o       (iters_s)
   );

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
   // which still fits the unsigned WIDTH-bit magnitude.
   assign a_mag_s = (signed_mode && a_in[WIDTH-1]) ? ({WIDTH{1'b0}} - a_in) : a_in;
   assign b_mag_s = (signed_mode && b_in[WIDTH-1]) ? ({WIDTH{1'b0}} - b_in) : b_in;

   // Accumulator value after the current iteration's conditional add.
   assign acc_next_s = acc_q + (mplier_q[0] ? mcand_q : {W2{1'b0}});

   // Multiplier after this iteration's shift would be zero.
   assign mplier_zero_s = (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         iter_q   <= '0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         iter_q   <= iter_d;
      end
   end

   // Datapath next-state: operand capture, shift-add step, result latch.
   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      prod_d   = prod_q;
      iter_d   = iter_q;

      if (load_s) begin
         mcand_d  = {{WIDTH{1'b0}}, a_mag_s};
         mplier_d = b_mag_s;
         acc_d    = {W2{1'b0}};
         neg_d    = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
      end else if (step_s) begin
         acc_d    = acc_next_s;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end else begin
         acc_d    = acc_q;
      end

      // Negating a zero magnitude yields zero, so neg needs no special case.
      if (finish_s) begin
         prod_d = neg_q ? ({W2{1'b0}} - acc_next_s) : acc_next_s;
         iter_d = iters_s;
      end else begin
         prod_d = prod_q;
      end
   end

   assign busy     = busy_s;
   assign done     = done_s;
   assign prod     = prod_q;
   assign iter_cnt = iter_q;

endmodule
